// File: rtl/slib_pkg.sv
// Shared helpers for the slib input-conditioning blocks: parameter limits
// and the filter counter width function.
package slib_pkg;

  localparam int WIDTH_MIN      = 1;
  localparam int WIDTH_MAX      = 32;
  localparam int STAGES_MIN     = 2;
  localparam int STAGES_MAX     = 4;
  localparam int FILTER_CNT_MIN = 1;
  localparam int FILTER_CNT_MAX = 255;

  function automatic int cnt_width(input int filter_cnt);
    return $clog2(filter_cnt + 1);
  endfunction

  function automatic bit params_ok(input int width, input int stages, input int filter_cnt);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (stages >= STAGES_MIN) && (stages <= STAGES_MAX) &&
           (filter_cnt >= FILTER_CNT_MIN) && (filter_cnt <= FILTER_CNT_MAX);
  endfunction

endpackage

// File: rtl/slib_input_filter_ch.sv
// One channel of the input filter: synchroniser chain, persistence counter,
// filtered level and registered edge pulses.
module slib_input_filter_ch
  import slib_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_CNT = 4,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic CE,
  input  logic D,
  output logic Q,
  output logic RISE,
  output logic FALL
);

  localparam int CW = cnt_width(FILTER_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CNT - 1);

  logic [STAGES-1:0] sync;
  logic [CW-1:0]     cnt;
  logic              s;

  assign s = sync[STAGES-1];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync <= {STAGES{RESET_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], D};
    end
  end

  // Any sample agreeing with Q restarts the persistence count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt  <= '0;
      Q    <= RESET_VAL;
      RISE <= 1'b0;
      FALL <= 1'b0;
    end else begin
      RISE <= 1'b0;
      FALL <= 1'b0;
      if (s == Q) begin
        cnt <= '0;
      end else if (CE) begin
        if (cnt == CNT_LAST) begin
          cnt  <= '0;
          Q    <= s;
          RISE <= s;
          FALL <= ~s;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/slib_input_filter.sv
// Multi-channel synchronising glitch filter; one independent
// slib_input_filter_ch per input bit.
module slib_input_filter
  import slib_pkg::*;
#(
  parameter int               WIDTH      = 1,
  parameter int               STAGES     = 2,
  parameter int               FILTER_CNT = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
);

  if (!params_ok(WIDTH, STAGES, FILTER_CNT)) begin : g_bad_params
    $error("slib_input_filter: WIDTH/STAGES/FILTER_CNT out of range");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    slib_input_filter_ch #(
      .STAGES     (STAGES),
      .FILTER_CNT (FILTER_CNT),
      .RESET_VAL  (RESET_VAL[i])
    ) u_ch (
      .CLK   (CLK),
      .RST_N (RST_N),
      .CE    (CE),
      .D     (D[i]),
      .Q     (Q[i]),
      .RISE  (RISE[i]),
      .FALL  (FALL[i])
    );
  end

endmodule

// File: tb/tb_slib_input_filter.sv
// Directed bench for slib_input_filter across four parameter sets.
module tb_slib_input_filter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // u1: W1 S2 F4
  logic ce1, d1, q1, rise1, fall1;
  // u2: W1 S2 F2, resets high
  logic ce2, d2, q2, rise2, fall2;
  // u8: W8 S2 F4
  logic ce8;
  logic [7:0] d8, q8, rise8, fall8;
  // u3: W1 S3 F1
  logic ce3, d3, q3, rise3, fall3;

  slib_input_filter #(.WIDTH(1), .STAGES(2), .FILTER_CNT(4), .RESET_VAL(1'b0)) u1 (
    .CLK(clk), .RST_N(rst_n), .CE(ce1), .D(d1), .Q(q1), .RISE(rise1), .FALL(fall1));
  slib_input_filter #(.WIDTH(1), .STAGES(2), .FILTER_CNT(2), .RESET_VAL(1'b1)) u2 (
    .CLK(clk), .RST_N(rst_n), .CE(ce2), .D(d2), .Q(q2), .RISE(rise2), .FALL(fall2));
  slib_input_filter #(.WIDTH(8), .STAGES(2), .FILTER_CNT(4), .RESET_VAL(8'h00)) u8 (
    .CLK(clk), .RST_N(rst_n), .CE(ce8), .D(d8), .Q(q8), .RISE(rise8), .FALL(fall8));
  slib_input_filter #(.WIDTH(1), .STAGES(3), .FILTER_CNT(1), .RESET_VAL(1'b0)) u3 (
    .CLK(clk), .RST_N(rst_n), .CE(ce3), .D(d3), .Q(q3), .RISE(rise3), .FALL(fall3));

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    d1 = 1'b0; d2 = 1'b1; d8 = 8'h00; d3 = 1'b0;
    ce1 = 1'b1; ce2 = 1'b0; ce8 = 1'b1; ce3 = 1'b1;
    step(3);
    tests_run++;
    if ({q1, rise1, fall1} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_u1 got q/rise/fall=%b required 000", {q1, rise1, fall1});
    end
    tests_run++;
    if ({q2, rise2, fall2} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_u2 got q/rise/fall=%b required 100", {q2, rise2, fall2});
    end
    tests_run++;
    if ({q8, rise8, fall8} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_u8 got q=%h rise=%h fall=%h required 00 00 00", q8, rise8, fall8);
    end
    tests_run++;
    if ({q3, rise3, fall3} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_u3 got q/rise/fall=%b required 000", {q3, rise3, fall3});
    end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_rise_latency;
    d1 = 1'b1;
    step(5);
    tests_run++;
    if ({q1, rise1} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rise_edge5 got q/rise=%b required 00", {q1, rise1});
    end
    step(1);
    tests_run++;
    if ({q1, rise1, fall1} !== 3'b110) begin
      tests_failed++;
      $display("FAIL rise_edge6 got q/rise/fall=%b required 110", {q1, rise1, fall1});
    end
    step(1);
    tests_run++;
    if ({q1, rise1, fall1} !== 3'b100) begin
      tests_failed++;
      $display("FAIL rise_edge7 got q/rise/fall=%b required 100", {q1, rise1, fall1});
    end
    d1 = 1'b0;
    step(5);
    tests_run++;
    if ({q1, fall1} !== 2'b10) begin
      tests_failed++;
      $display("FAIL fall_edge5 got q/fall=%b required 10", {q1, fall1});
    end
    step(1);
    tests_run++;
    if ({q1, rise1, fall1} !== 3'b001) begin
      tests_failed++;
      $display("FAIL fall_edge6 got q/rise/fall=%b required 001", {q1, rise1, fall1});
    end
    step(1);
    tests_run++;
    if ({q1, rise1, fall1} !== 3'b000) begin
      tests_failed++;
      $display("FAIL fall_edge7 got q/rise/fall=%b required 000", {q1, rise1, fall1});
    end
  endtask

  task automatic test_glitch;
    int bad = 0;
    d1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) d1 = 1'b0;
      step(1);
      if ({q1, rise1, fall1} !== 3'b000) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL glitch3 got %0d cycles with q/rise/fall active required 0", bad);
    end
  endtask

  // CE high only on every 4th edge; S differs from Q from edge 3 on,
  // so qualified edges are 4 (count) and 8 (update).
  task automatic test_ce;
    int bad = 0;
    d2 = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      ce2 = (i % 4 == 0);
      step(1);
      if ({q2, rise2, fall2} !== 3'b100) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ce_hold got %0d early-change cycles required 0", bad);
    end
    ce2 = 1'b1;
    step(1);
    tests_run++;
    if ({q2, rise2, fall2} !== 3'b001) begin
      tests_failed++;
      $display("FAIL ce_fall_edge8 got q/rise/fall=%b required 001", {q2, rise2, fall2});
    end
    ce2 = 1'b0;
    step(1);
    tests_run++;
    if ({q2, rise2, fall2} !== 3'b000) begin
      tests_failed++;
      $display("FAIL ce_fall_edge9 got q/rise/fall=%b required 000", {q2, rise2, fall2});
    end
  endtask

  task automatic test_multi;
    d8 = 8'hA5;
    step(5);
    tests_run++;
    if ({q8, rise8} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL multi_a5_edge5 got q=%h rise=%h required 00 00", q8, rise8);
    end
    step(1);
    tests_run++;
    if ({q8, rise8, fall8} !== {8'hA5, 8'hA5, 8'h00}) begin
      tests_failed++;
      $display("FAIL multi_a5_edge6 got q=%h rise=%h fall=%h required a5 a5 00", q8, rise8, fall8);
    end
    step(1);
    tests_run++;
    if ({q8, rise8, fall8} !== {8'hA5, 8'h00, 8'h00}) begin
      tests_failed++;
      $display("FAIL multi_a5_edge7 got q=%h rise=%h fall=%h required a5 00 00", q8, rise8, fall8);
    end
    d8 = 8'h5A;
    step(6);
    tests_run++;
    if ({q8, rise8, fall8} !== {8'h5A, 8'h5A, 8'hA5}) begin
      tests_failed++;
      $display("FAIL multi_5a_edge6 got q=%h rise=%h fall=%h required 5a 5a a5", q8, rise8, fall8);
    end
    step(1);
    tests_run++;
    if ({rise8, fall8} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL multi_5a_edge7 got rise=%h fall=%h required 00 00", rise8, fall8);
    end
  endtask

  task automatic test_single_pulse;
    d3 = 1'b1;
    step(1);
    d3 = 1'b0;
    step(2);
    tests_run++;
    if ({q3, rise3, fall3} !== 3'b000) begin
      tests_failed++;
      $display("FAIL pulse_edge3 got q/rise/fall=%b required 000", {q3, rise3, fall3});
    end
    step(1);
    tests_run++;
    if ({q3, rise3, fall3} !== 3'b110) begin
      tests_failed++;
      $display("FAIL pulse_edge4 got q/rise/fall=%b required 110", {q3, rise3, fall3});
    end
    step(1);
    tests_run++;
    if ({q3, rise3, fall3} !== 3'b001) begin
      tests_failed++;
      $display("FAIL pulse_edge5 got q/rise/fall=%b required 001", {q3, rise3, fall3});
    end
    step(1);
    tests_run++;
    if ({q3, rise3, fall3} !== 3'b000) begin
      tests_failed++;
      $display("FAIL pulse_edge6 got q/rise/fall=%b required 000", {q3, rise3, fall3});
    end
  endtask

  // Count reaches 2 after edge 4; reset must throw that progress away.
  task automatic test_reset_mid;
    int bad = 0;
    d1 = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({q1, rise1, fall1} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rstmid_assert got q/rise/fall=%b required 000", {q1, rise1, fall1});
    end
    step(2);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      if ({q1, rise1, fall1} !== 3'b000) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL rstmid_early got %0d early-change cycles required 0", bad);
    end
    step(1);
    tests_run++;
    if ({q1, rise1, fall1} !== 3'b110) begin
      tests_failed++;
      $display("FAIL rstmid_edge6 got q/rise/fall=%b required 110", {q1, rise1, fall1});
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_ce();
    test_multi();
    test_single_pulse();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/slib_input_filter.md
SLIB_INPUT_FILTER -- requirements
Module: slib_input_filter

Interface
REQ-001 Parameter WIDTH, default 1, number of independent input channels (1..32).
REQ-002 Parameter STAGES, default 2, synchroniser flop depth per channel (2..4).
REQ-003 Parameter FILTER_CNT, default 4, consecutive qualifying samples before an output changes (1..255).
REQ-004 Parameter RESET_VAL, default all-zero, WIDTH-bit reset value of synchroniser chain and Q.
REQ-005 CLK  input  1  single clock; all logic rising-edge.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 CE  input  1  sample enable; filter counters and Q advance only when high.
REQ-008 D  input  WIDTH  asynchronous raw inputs.
REQ-009 Q  output  WIDTH  synchronised, filtered level.
REQ-010 RISE  output  WIDTH  one-cycle pulse per channel when Q goes 0->1.
REQ-011 FALL  output  WIDTH  one-cycle pulse per channel when Q goes 1->0.

Function
REQ-012 Each channel SHALL pass D through STAGES flops clocked every CLK regardless of CE; last stage = S.
REQ-013 Per channel, a counter (width clog2(FILTER_CNT+1)) SHALL clear on any cycle where S equals Q.
REQ-014 When S differs from Q and CE is high, the counter SHALL increment by one.
REQ-015 When S differs from Q, CE is high and counter equals FILTER_CNT-1, Q SHALL take S on that edge and the counter SHALL clear.
REQ-016 When CE is low and S differs from Q, counter and Q SHALL hold.
REQ-017 A glitch on S shorter than FILTER_CNT consecutive CE-qualified cycles SHALL never reach Q.
REQ-018 With CE tied high, latency from a stable D change to Q change SHALL be exactly STAGES+FILTER_CNT CLK edges.
REQ-019 RISE/FALL SHALL be registered, asserted for exactly one CLK cycle coincident with the cycle Q first shows the new value.
REQ-020 RISE and FALL for one channel SHALL never be high in the same cycle.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-013..019.
REQ-022 Counter SHALL never exceed FILTER_CNT-1 (no wrap).
REQ-023 Parameter values outside stated ranges SHALL cause an elaboration-time error.

Reset
REQ-024 RST_N low SHALL immediately set synchroniser flops and Q to RESET_VAL, counters to 0, RISE/FALL to 0.
REQ-025 Reset assertion mid-filtering SHALL discard partial counts; no RISE/FALL pulse SHALL be generated by reset assertion or release.
REQ-026 After release, if D differs from RESET_VAL, Q SHALL change per REQ-018 measured from the first edge after release.

Structure
REQ-027 Counter-width function and parameter range limits SHALL reside in shared package slib_pkg.
REQ-028 One sub-module slib_input_filter_ch (single channel: sync chain, counter, Q, edge pulses) SHALL be instantiated WIDTH times via generate.
REQ-029 No combinational path SHALL exist from D or CE to any output.

Verification
REQ-030 WIDTH=1, STAGES=2, FILTER_CNT=4, CE=1: D 0->1 held -> Q=1 and RISE=1 for one cycle at edge 6.
REQ-031 Same config: D high for 3 cycles then low -> Q stays 0, no RISE/FALL.
REQ-032 CE high every 4th cycle, FILTER_CNT=2: D 1->0 held -> Q falls on the 2nd CE-high cycle after S changes, FALL pulse 1 cycle.
REQ-033 WIDTH=8, D=0xA5 from reset 0x00 -> Q=0xA5, RISE=0xA5, FALL=0x00 in one cycle; then D=0x5A -> RISE=0x5A, FALL=0xA5 in one cycle.
REQ-034 RST_N pulsed low at counter=2 with D=1 -> Q=0, counters 0, no pulses; after release Q rises exactly 6 edges later.
REQ-035 FILTER_CNT=1, STAGES=3, CE=1: single-cycle D pulse -> Q pulses high for one cycle 4 edges later, RISE then FALL on consecutive cycles.
